// File: rtl/reg_read_pkg.sv
// Shared constants and state encoding for the register upper-byte reader.
// The LUI_SHIFT constant is common with the lui write path (imm8 << 8).
package reg_read_pkg;

    localparam int REG_AW    = 4;
    localparam int DATA_W    = 16;
    localparam int IMM_W     = 8;
    localparam int LUI_SHIFT = DATA_W - IMM_W;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_CAPTURE,
        ST_PRESENT,
        ST_DONE
    } state_t;

    // Recovers the lui immediate from a register value.
    function automatic logic [IMM_W-1:0] upper_imm(input logic [DATA_W-1:0] data);
        logic [DATA_W-1:0] shifted;
        shifted   = data >> LUI_SHIFT;
        upper_imm = shifted[IMM_W-1:0];
    endfunction

endpackage

// File: rtl/reg_range_counter.sv
// Register range walker: holds the current index and the last index of a scan.
// load captures the range, inc steps idx with natural 4-bit wrap (15 -> 0).
module reg_range_counter
    import reg_read_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              load,
    input  logic              inc,
    input  logic [REG_AW-1:0] first_reg,
    input  logic [REG_AW-1:0] last_reg,
    output logic [REG_AW-1:0] idx,
    output logic              is_last
);

    logic [REG_AW-1:0] last;

    // Range registers: load on scan start, step on each accepted result.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock) begin
        if (!reset) begin
            idx  <= '0;
            last <= '0;
        end else if (load) begin
            idx  <= first_reg;
            last <= last_reg;
        end else if (inc) begin
            idx  <= idx + 1'b1;
        end
    end

    assign is_last = (idx == last);

endmodule

// File: rtl/reg_upper_reader.sv
// Sequential read-back unit: walks a RegFile range through one read port and
// presents each register's upper-byte immediate on a valid/ready output.
// Optional macro LUI_FORM_CHECK_EN adds lui_err (low byte non-zero flag).
module reg_upper_reader
    import reg_read_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [REG_AW-1:0] first_reg,
    input  logic [REG_AW-1:0] last_reg,
    output logic [REG_AW-1:0] read_reg,
    input  logic [DATA_W-1:0] read_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [REG_AW-1:0] out_reg,
    output logic [IMM_W-1:0]  out_imm,
    output logic [IMM_W-1:0]  out_low,
    output logic              busy,
    output logic              done
`ifdef LUI_FORM_CHECK_EN
    ,
    output logic              lui_err
`endif
);

    state_t            state;
    state_t            state_next;
    logic [REG_AW-1:0] idx;
    logic              is_last;
    logic              accept;
    logic              load;
    logic              inc;

    assign accept = out_valid && out_ready;
    assign load   = (state == ST_IDLE) && start;
    assign inc    = (state == ST_PRESENT) && accept && !is_last;

    reg_range_counter u_range (
        .clock     (clock),
        .reset     (reset),
        .load      (load),
        .inc       (inc),
        .first_reg (first_reg),
        .last_reg  (last_reg),
        .idx       (idx),
        .is_last   (is_last)
    );

    // State register; busy and done are registered from the next state.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_next;
            busy  <= (state_next != ST_IDLE);
            done  <= (state_next == ST_DONE);
        end
    end

    // Next-state logic for the scan sequence.
    // NOTE: state_next gets a default first so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:    if (start) state_next = ST_ISSUE;
            ST_ISSUE:   state_next = ST_CAPTURE;
            ST_CAPTURE: state_next = ST_PRESENT;
            ST_PRESENT: if (accept) state_next = is_last ? ST_DONE : ST_ISSUE;
            ST_DONE:    state_next = ST_IDLE;
            default:    state_next = ST_IDLE;
        endcase
    end

    // Read-port address and result registers; data holds steady while presented.
    always_ff @(posedge clock) begin
        if (!reset) begin
            read_reg  <= '0;
            out_valid <= 1'b0;
            out_reg   <= '0;
            out_imm   <= '0;
            out_low   <= '0;
        end else begin
            case (state)
                ST_ISSUE: read_reg <= idx;
                ST_CAPTURE: begin
                    out_imm   <= upper_imm(read_data);
                    out_low   <= read_data[IMM_W-1:0];
                    out_reg   <= idx;
                    out_valid <= 1'b1;
                end
                ST_PRESENT: if (accept) out_valid <= 1'b0;
                default: ;
            endcase
        end
    end

`ifdef LUI_FORM_CHECK_EN
    // Flags a captured value whose low byte is non-zero (not lui-form).
    always_ff @(posedge clock) begin
        if (!reset) begin
            lui_err <= 1'b0;
        end else if (state == ST_CAPTURE) begin
            lui_err <= (read_data[IMM_W-1:0] != '0);
        end else if (state == ST_PRESENT && accept) begin
            lui_err <= 1'b0;
        end
    end
`endif

endmodule
